grng_sample_collector: RTL

// - Sits directly downstream of the ziggurat decision unit (the OpUnit stage).
// - Aligns each issued candidate with the decision that unit registers one cycle later.
// - Selects the accepted Gaussian sample: the normal/wedge candidate, or the tail result.
// - Buffers samples in a FIFO with a valid/ready output, back-pressures the sample issuer,
//   and keeps accept/reject/tail statistics.

---
 rtl/grng_pkg.sv | 15 +
 rtl/grng_sample_fifo.sv | 52 +++++
 rtl/grng_sample_collector.sv | 93 +++++++++
 3 files changed

// File: rtl/grng_pkg.sv
// Shared definitions for the Gaussian RNG datapath: Q7.28 sample format and
// the ziggurat tail-classification helper.
package grng_pkg;

    localparam int Q_W    = 36;
    localparam int Q_FRAC = 28;
    localparam int IDX_W  = 8;

    // A candidate belongs to the tail path when it came from the base strip
    // (rect_idx 0) or while the tail sampler is still iterating.
    function automatic logic is_tail(input logic [IDX_W-1:0] idx, input logic do_while);
        return (idx == '0) || do_while;
    endfunction

endpackage

// File: rtl/grng_sample_fifo.sv
// DEPTH-entry sample FIFO: synchronous write, asynchronous fall-through read,
// occupancy count exported so the collector can compute back-pressure.
module grng_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int LOG2D = 4,
    parameter int W     = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic [LOG2D:0]   count
);

    localparam logic [LOG2D:0] FULL = DEPTH[LOG2D:0];

    logic [W-1:0]     mem [DEPTH];
    logic [LOG2D-1:0] wr_ptr;
    logic [LOG2D-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign rd_en    = pop && (count != '0);
    assign wr_en    = push && ((count != FULL) || rd_en);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/grng_sample_collector.sv
// Pairs each issued ziggurat candidate with the decision registered one cycle
// later, queues accepted samples and keeps accept/reject/tail statistics.
module grng_sample_collector
    import grng_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LOG2D = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_rect_idx,
    input  logic [Q_W-1:0]   in_mult_value,
    input  logic             op_tail_case,
    input  logic             op_do_while,
    input  logic             op_reject,
    input  logic [Q_W-1:0]   op_value,
    output logic             in_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [Q_W-1:0]   m_data,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] rej_cnt,
    output logic [CNT_W-1:0] tail_cnt
);

    localparam int               READY_LIM = DEPTH - 2;
    localparam logic [LOG2D+1:0] READY_MAX = READY_LIM[LOG2D+1:0];

    logic             pend_v;
    logic             pend_tail;
    logic [Q_W-1:0]   pend_x;
    logic [LOG2D:0]   count;
    logic             issue;
    logic             push;
    logic             pop;
    logic [Q_W-1:0]   push_data;
    logic [Q_W-1:0]   fifo_data;
    logic             unused_tail_case;

    // Handshakes: a candidate transfers when in_valid && in_ready, a sample
    // when m_valid && m_ready, both on the rising clock edge; neither ready
    // depends combinationally on its own valid.
    // in_ready reserves room for the pending decision plus the one issued now.
    assign in_ready  = ({1'b0, count} + {{(LOG2D + 1){1'b0}}, pend_v}) <= READY_MAX;
    assign issue     = in_valid && in_ready;
    assign push      = pend_v && (pend_tail ? !op_do_while : !op_reject);
    assign push_data = pend_tail ? op_value : pend_x;
    assign m_valid   = (count != '0);
    assign pop       = m_valid && m_ready;
    assign m_data    = m_valid ? fifo_data : '0;

    // The decision unit's tail flag is implied by rect_idx/do_while already.
    assign unused_tail_case = op_tail_case;

    grng_sample_fifo #(
        .DEPTH (DEPTH),
        .LOG2D (LOG2D),
        .W     (Q_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v    <= 1'b0;
            pend_tail <= 1'b0;
            pend_x    <= '0;
            acc_cnt   <= '0;
            rej_cnt   <= '0;
            tail_cnt  <= '0;
        end else begin
            pend_v <= issue;
            if (issue) begin
                pend_tail <= is_tail(in_rect_idx, op_do_while);
                pend_x    <= in_mult_value;
            end
            if (push) acc_cnt <= acc_cnt + 1'b1;
            if (push && pend_tail) tail_cnt <= tail_cnt + 1'b1;
            if (pend_v && !pend_tail && op_reject) rej_cnt <= rej_cnt + 1'b1;
        end
    end

    a_no_issue_when_busy : assert property (@(posedge clk) disable iff (!rst_n) !(in_valid && !in_ready));

endmodule
